vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, H/V counters, sync/blank
// generation with a pixel-tick delay line to match the downstream colour pipeline latency.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned PIPE_DLY = 0,
    parameter int unsigned CW       = 10
) (
    input  logic          Clk,
    input  logic          Reset_N,
    input  logic          Enable,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic          Pixel_En,
    output logic [CW-1:0] Draw_X,
    output logic [CW-1:0] Draw_Y,
    output logic          Line_Start,
    output logic          Frame_Start,
    output logic          Vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [2:0] IDLE_VEC = {~HS_POL, ~VS_POL, 1'b0};

    logic [DW-1:0] div_q, div_d;
    logic          vga_clk_q;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hs_raw_q, vs_raw_q, bn_raw_q;
    logic          hs_d, vs_d, bn_d;
    logic          pixel_en;
    logic [2:0]    raw_vec, out_vec;

    assign pixel_en = Enable && (div_q == DIV_LAST);

    // Next-count values; only loaded into the registers on a pixel tick.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        x_d   = x_q + 1'b1;
        y_d   = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
        hs_d = ((x_d >= H_SS) && (x_d < H_SE)) ? HS_POL : ~HS_POL;
        vs_d = ((y_d >= V_SS) && (y_d < V_SE)) ? VS_POL : ~VS_POL;
        bn_d = (x_d < H_ACT) && (y_d < V_ACT);
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hs_raw_q  <= ~HS_POL;
            vs_raw_q  <= ~VS_POL;
            bn_raw_q  <= 1'b0;
        end else if (Enable) begin
            div_q     <= div_d;
            vga_clk_q <= (div_d >= DIV_HALF);
            if (pixel_en) begin
                x_q      <= x_d;
                y_q      <= y_d;
                hs_raw_q <= hs_d;
                vs_raw_q <= vs_d;
                bn_raw_q <= bn_d;
            end
        end
    end

    assign raw_vec = {hs_raw_q, vs_raw_q, bn_raw_q};

    if (PIPE_DLY == 0) begin : g_nodly
        assign out_vec = raw_vec;
    end else begin : g_dly
        logic [2:0] dly_q [PIPE_DLY];

        always_ff @(posedge Clk or negedge Reset_N) begin
            if (!Reset_N) begin
                for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= IDLE_VEC;
            end else if (pixel_en) begin
                dly_q[0] <= raw_vec;
                for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign out_vec = dly_q[PIPE_DLY-1];
    end

    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = out_vec[2];
    assign VGA_VS      = out_vec[1];
    assign VGA_BLANK_N = out_vec[0];
    assign VGA_SYNC_N  = 1'b0;
    assign Pixel_En    = pixel_en;
    assign Draw_X      = x_q;
    assign Draw_Y      = y_q;
    assign Line_Start  = pixel_en && (x_q == '0);
    assign Frame_Start = pixel_en && (x_q == '0) && (y_q == '0);
    assign Vblank      = (y_q >= V_ACT);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-geometry instances (14x7 raster) checked cycle by cycle
// against a reference raster model, plus directed checks on strobes, freeze and async reset.
module tb_vga_timing_gen;

    localparam int HT  = 14;
    localparam int VT  = 7;
    localparam int HA  = 8;
    localparam int HSS = 10;
    localparam int HSE = 12;
    localparam int VA  = 4;
    localparam int VSS = 5;
    localparam int VSE = 6;

    logic Clk = 1'b0;
    logic Reset_N = 1'b0;
    logic Enable = 1'b1;

    logic       a_vclk, a_hs, a_vs, a_bn, a_sn, a_pe, a_ls, a_fs, a_vb;
    logic [5:0] a_dx, a_dy;
    logic       b_vclk, b_hs, b_vs, b_bn, b_sn, b_pe, b_ls, b_fs, b_vb;
    logic [5:0] b_dx, b_dy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    always #5 Clk = ~Clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(4), .PIPE_DLY(0), .CW(6)
    ) u_dut_a (
        .Clk(Clk), .Reset_N(Reset_N), .Enable(Enable),
        .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn),
        .VGA_SYNC_N(a_sn), .Pixel_En(a_pe), .Draw_X(a_dx), .Draw_Y(a_dy),
        .Line_Start(a_ls), .Frame_Start(a_fs), .Vblank(a_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(2), .PIPE_DLY(3), .CW(6)
    ) u_dut_b (
        .Clk(Clk), .Reset_N(Reset_N), .Enable(Enable),
        .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn),
        .VGA_SYNC_N(b_sn), .Pixel_En(b_pe), .Draw_X(b_dx), .Draw_Y(b_dy),
        .Line_Start(b_ls), .Frame_Start(b_fs), .Vblank(b_vb)
    );

    typedef struct packed {
        int         div;
        int         x;
        int         y;
        logic       vclk;
        logic [2:0] raw;   // {hs, vs, blank_n} undelayed
        logic [11:0] pipe; // stage k at [3k+2:3k]
    } model_t;

    model_t ma, mb;

    function automatic logic [2:0] raw_of(int x, int y, logic hp, logic vp);
        logic hs, vs, bn;
        hs = (x >= HSS && x < HSE) ? hp : ~hp;
        vs = (y >= VSS && y < VSE) ? vp : ~vp;
        bn = (x < HA) && (y < VA);
        return {hs, vs, bn};
    endfunction

    function automatic model_t m_reset(logic hp, logic vp);
        model_t m;
        m.div  = 0;
        m.x    = 0;
        m.y    = 0;
        m.vclk = 1'b0;
        m.raw  = {~hp, ~vp, 1'b0};
        m.pipe = {4{~hp, ~vp, 1'b0}};
        return m;
    endfunction

    function automatic model_t m_step(model_t m, int cdiv, logic hp, logic vp);
        model_t n;
        n = m;
        if (m.div == cdiv - 1) begin
            if (m.x == HT - 1) begin
                n.x = 0;
                n.y = (m.y == VT - 1) ? 0 : m.y + 1;
            end else begin
                n.x = m.x + 1;
            end
            n.pipe = {m.pipe[8:0], m.raw};
            n.raw  = raw_of(n.x, n.y, hp, vp);
        end
        n.div  = (m.div + 1) % cdiv;
        n.vclk = (n.div >= cdiv / 2);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string p, input model_t m, input int cdiv, input int dly,
                             input logic [5:0] dx, input logic [5:0] dy, input logic vclk,
                             input logic hs, input logic vs, input logic bn, input logic sn,
                             input logic pe, input logic ls, input logic fs, input logic vb);
        logic       pe_e;
        logic [2:0] o;
        pe_e = Reset_N && Enable && (m.div == cdiv - 1);
        o    = m.raw;
        if (dly > 0) o = m.pipe[3*dly-1 -: 3];
        chk({p, "_draw_x"}, 32'(dx), m.x);
        chk({p, "_draw_y"}, 32'(dy), m.y);
        chk({p, "_vga_clk"}, 32'(vclk), 32'(m.vclk));
        chk({p, "_hs"}, 32'(hs), 32'(o[2]));
        chk({p, "_vs"}, 32'(vs), 32'(o[1]));
        chk({p, "_blank_n"}, 32'(bn), 32'(o[0]));
        chk({p, "_sync_n"}, 32'(sn), 32'd0);
        chk({p, "_pixel_en"}, 32'(pe), 32'(pe_e));
        chk({p, "_line_start"}, 32'(ls), 32'(pe_e && m.x == 0));
        chk({p, "_frame_start"}, 32'(fs), 32'(pe_e && m.x == 0 && m.y == 0));
        chk({p, "_vblank"}, 32'(vb), 32'(m.y >= VA));
    endtask

    task automatic check_all();
        check_out("a", ma, 4, 0, a_dx, a_dy, a_vclk, a_hs, a_vs, a_bn, a_sn, a_pe, a_ls, a_fs,
                  a_vb);
        check_out("b", mb, 2, 3, b_dx, b_dy, b_vclk, b_hs, b_vs, b_bn, b_sn, b_pe, b_ls, b_fs,
                  b_vb);
    endtask

    // Advance one Clk; the models follow the DUT state update at the edge.
    task automatic tick();
        @(posedge Clk);
        if (Reset_N && Enable) begin
            ma = m_step(ma, 4, 1'b0, 1'b0);
            mb = m_step(mb, 2, 1'b1, 1'b1);
        end
        cyc++;
        #1;
    endtask

    initial begin
        int rel, first_a, first_b, last_fs, ls_cnt, pe_cnt, found;
        bit ls_seen, fs_seen;

        // Reset held
        ma = m_reset(1'b0, 1'b0);
        mb = m_reset(1'b1, 1'b1);
        repeat (3) tick();
        check_all();
        chk("a_reset_hs_deasserted", 32'(a_hs), 32'd1);
        chk("b_reset_hs_deasserted", 32'(b_hs), 32'd0);

        // Release, run two A frames with strobe spacing checks
        @(negedge Clk);
        Reset_N = 1'b1;
        rel = cyc;
        first_a = -1;
        first_b = -1;
        last_fs = -1;
        ls_cnt = 0;
        pe_cnt = 0;
        ls_seen = 1'b0;
        fs_seen = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            check_all();
            if (a_pe && first_a < 0) begin
                first_a = cyc - rel;
                chk("a_fs_on_first_pe", 32'(a_fs), 32'd1);
            end
            if (b_pe && first_b < 0) begin
                first_b = cyc - rel;
                chk("b_fs_on_first_pe", 32'(b_fs), 32'd1);
            end
            if (a_fs) begin
                if (fs_seen) begin
                    chk("a_frame_len", cyc - last_fs, 392);
                    chk("a_lines_per_frame", ls_cnt, 7);
                end
                fs_seen = 1'b1;
                last_fs = cyc;
                ls_cnt = 0;
            end
            if (a_ls) begin
                if (ls_seen) chk("a_pixels_per_line", pe_cnt, 14);
                ls_seen = 1'b1;
                pe_cnt = 0;
                ls_cnt++;
            end
            if (a_pe) pe_cnt++;
        end
        chk("a_first_pe_cycle", first_a, 3);
        chk("b_first_pe_cycle", first_b, 1);

        // Freeze at A (6,2) for 100 cycles
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            tick();
            check_all();
            if (ma.x == 6 && ma.y == 2) found = 1;
        end
        chk("seek_freeze_pos", found, 1);
        Enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check_all();
            chk("a_freeze_x", 32'(a_dx), 32'd6);
            chk("a_freeze_y", 32'(a_dy), 32'd2);
        end
        Enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            check_all();
        end

        // Async reset mid-line while A HS is active
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            tick();
            check_all();
            if (ma.x == 10 && ma.div == 1) found = 1;
        end
        chk("seek_reset_pos", found, 1);
        chk("a_hs_active_x10", 32'(a_hs), 32'd0);
        #2;
        Reset_N = 1'b0;
        #1;
        ma = m_reset(1'b0, 1'b0);
        mb = m_reset(1'b1, 1'b1);
        check_all();
        chk("a_async_rst_x", 32'(a_dx), 32'd0);
        chk("a_async_rst_vclk", 32'(a_vclk), 32'd0);
        chk("a_async_rst_blank_n", 32'(a_bn), 32'd0);
        repeat (2) begin
            tick();
            check_all();
        end
        @(negedge Clk);
        Reset_N = 1'b1;
        rel = cyc;
        first_a = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            check_all();
            if (a_pe && first_a < 0) begin
                first_a = cyc - rel;
                chk("a_fs_after_reset", 32'(a_fs), 32'd1);
            end
        end
        chk("a_first_pe_after_reset", first_a, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
